// File: rtl/ir_key_dec.sv
// IR remote key decoder: validates NEC-style frames and queues command bytes in a show-ahead FIFO.
// Optional repeat-hold support is compiled in with the IR_KEY_REPEAT_EN macro.
module ir_key_dec #(
    parameter logic [7:0]  DEV_ADDR = 8'h00,
    parameter bit          CHK_ADDR = 1'b1,
    parameter int unsigned FIFO_AW  = 2,
    parameter int unsigned REP_TMO  = 6000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_data,
    input  logic        i_data_vld,
    input  logic        i_repeat,
    input  logic        i_key_rdy,
    output logic [7:0]  o_key,
    output logic        o_key_vld,
    output logic        o_fifo_full,
    output logic [7:0]  o_err_cnt
);

    // state | meaning
    // IDLE  | waiting for a frame (or a repeat code)
    // CHECK | frame held in data_r, validity evaluated
    // PUSH  | write command byte into the FIFO unless it is full
    // DROP  | frame rejected, error counted
    typedef enum logic [1:0] {IDLE, CHECK, PUSH, DROP} state_t;

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] OCC_FULL = {1'b1, {FIFO_AW{1'b0}}};

    state_t state, state_nxt;

    logic [31:0]        data_r;
    logic               rep_r;
    logic               frame_ok;
    logic               rep_take;
    logic               rep_miss;
    logic [7:0]         rep_key;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW:0]   wptr, rptr;
    logic [FIFO_AW:0]   occ;
    logic               empty, full;
    logic               pop, push_ok, push_drop;

    logic               ign_vld;
    logic               err_evt;
    logic [1:0]         err_inc;
    logic [8:0]         err_sum;

    assign frame_ok = (data_r[15:8] == ~data_r[7:0]) &&
                      (data_r[31:24] == ~data_r[23:16]) &&
                      (!CHK_ADDR || (data_r[31:24] == DEV_ADDR));

`ifdef IR_KEY_REPEAT_EN
    localparam logic [23:0] REP_TMO_C = REP_TMO[23:0];

    logic [7:0]  last_key;
    logic        last_vld;
    logic [23:0] tmo_cnt;

    // A simultaneous new frame wins over a repeat code.
    assign rep_take = (state == IDLE) && !i_data_vld && i_repeat && last_vld;
    assign rep_miss = (state == IDLE) && !i_data_vld && i_repeat && !last_vld;
    assign rep_key  = last_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key <= 8'h00;
            last_vld <= 1'b0;
            tmo_cnt  <= 24'd0;
        end else if (state == CHECK && !rep_r && frame_ok) begin
            last_key <= data_r[15:8];
            last_vld <= 1'b1;
            tmo_cnt  <= 24'd0;
        end else if (rep_take) begin
            tmo_cnt  <= 24'd0;
        end else if (state == DROP) begin
            last_vld <= 1'b0;
        end else if (last_vld) begin
            if (tmo_cnt == REP_TMO_C) begin
                last_vld <= 1'b0;
            end else begin
                tmo_cnt <= tmo_cnt + 24'd1;
            end
        end
    end
`else
    logic unused_repeat;

    assign rep_take      = 1'b0;
    assign rep_miss      = 1'b0;
    assign rep_key       = 8'h00;
    assign unused_repeat = i_repeat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Repeat codes also pass through CHECK so their push latency matches a frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_data_vld || rep_take) state_nxt = CHECK;
            CHECK:   state_nxt = (rep_r || frame_ok) ? PUSH : DROP;
            PUSH:    state_nxt = IDLE;
            DROP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= 32'h0000_0000;
            rep_r  <= 1'b0;
        end else if (state == IDLE && i_data_vld) begin
            data_r <= i_data;
            rep_r  <= 1'b0;
        end else if (rep_take) begin
            data_r <= {data_r[31:16], rep_key, data_r[7:0]};
            rep_r  <= 1'b1;
        end
    end

    // Full is judged on occupancy before any same-cycle pop.
    assign occ       = wptr - rptr;
    assign empty     = (wptr == rptr);
    assign full      = (occ == OCC_FULL);
    assign pop       = !empty && i_key_rdy;
    assign push_ok   = (state == PUSH) && !full;
    assign push_drop = (state == PUSH) && full;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[FIFO_AW-1:0]] <= data_r[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
        end
    end

    assign o_key       = empty ? 8'h00 : mem[rptr[FIFO_AW-1:0]];
    assign o_key_vld   = !empty;
    assign o_fifo_full = full;

    // An ignored frame can coincide with a DROP or a full-FIFO discard.
    assign ign_vld = i_data_vld && (state != IDLE);
    assign err_evt = (state == DROP) || push_drop || rep_miss;

    always_comb begin
        err_inc = {1'b0, ign_vld} + {1'b0, err_evt};
        err_sum = {1'b0, o_err_cnt} + {7'b0, err_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err_cnt <= 8'h00;
        end else begin
            o_err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

endmodule

// File: tb/tb_ir_key_dec.sv
// Self-checking bench for ir_key_dec: directed scenarios plus a randomized run against a
// transaction-level model (queue of keys, fixed two-cycle decision latency).
module tb_ir_key_dec;

    localparam logic [7:0] DEV = 8'h00;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_data;
    logic        i_data_vld;
    logic        i_repeat;
    logic        i_key_rdy;
    logic [7:0]  o_key;
    logic        o_key_vld;
    logic        o_fifo_full;
    logic [7:0]  o_err_cnt;

    int checks;
    int failures;

    typedef struct {
        int         cyc;
        bit         ok;
        logic [7:0] key;
    } ev_t;

    ir_key_dec #(
        .DEV_ADDR (DEV),
        .CHK_ADDR (1'b1),
        .FIFO_AW  (2),
        .REP_TMO  (1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data      (i_data),
        .i_data_vld  (i_data_vld),
        .i_repeat    (i_repeat),
        .i_key_rdy   (i_key_rdy),
        .o_key       (o_key),
        .o_key_vld   (o_key_vld),
        .o_fifo_full (o_fifo_full),
        .o_err_cnt   (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        i_data     = 32'h0;
        i_data_vld = 1'b0;
        i_repeat   = 1'b0;
        i_key_rdy  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse(input logic [31:0] d);
        i_data     = d;
        i_data_vld = 1'b1;
        tick(1);
        i_data_vld = 1'b0;
    endtask

    task automatic send_wait(input logic [31:0] d);
        pulse(d);
        tick(3);
    endtask

    function automatic logic [31:0] mk_frame(input logic [7:0] a, input logic [7:0] c);
        return {a, ~a, c, ~c};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b exp=0", o_key_vld); end
        checks++; if (o_key !== 8'h00) begin failures++; $display("FAIL reset_key got=%h exp=00", o_key); end
        checks++; if (o_fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", o_fifo_full); end
        checks++; if (o_err_cnt !== 8'h00) begin failures++; $display("FAIL reset_err got=%h exp=00", o_err_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        pulse(32'h00FF_45BA);
        tick(1);
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL basic_early_vld got=%0b exp=0", o_key_vld); end
        tick(1);
        checks++; if (o_key_vld !== 1'b1) begin failures++; $display("FAIL basic_vld got=%0b exp=1", o_key_vld); end
        checks++; if (o_key !== 8'h45) begin failures++; $display("FAIL basic_key got=%h exp=45", o_key); end
        checks++; if (o_err_cnt !== 8'h00) begin failures++; $display("FAIL basic_err got=%h exp=00", o_err_cnt); end
        i_key_rdy = 1'b1;
        tick(1);
        i_key_rdy = 1'b0;
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL basic_pop_vld got=%0b exp=0", o_key_vld); end
        i_key_rdy = 1'b1;
        tick(2);
        i_key_rdy = 1'b0;
        checks++; if (o_key !== 8'h00) begin failures++; $display("FAIL basic_empty_key got=%h exp=00", o_key); end
    endtask

    task automatic test_reject();
        do_reset();
        send_wait(32'h00FF_4545);
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL rej_cmd_vld got=%0b exp=0", o_key_vld); end
        checks++; if (o_err_cnt !== 8'd1) begin failures++; $display("FAIL rej_cmd_err got=%0d exp=1", o_err_cnt); end
        send_wait(32'h01FE_45BA);
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL rej_addr_vld got=%0b exp=0", o_key_vld); end
        checks++; if (o_err_cnt !== 8'd2) begin failures++; $display("FAIL rej_addr_err got=%0d exp=2", o_err_cnt); end
        send_wait(32'h00FE_45BA);
        checks++; if (o_err_cnt !== 8'd3) begin failures++; $display("FAIL rej_ainv_err got=%0d exp=3", o_err_cnt); end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 1; k <= 4; k++) send_wait(mk_frame(DEV, 8'(k)));
        checks++; if (o_fifo_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%0b exp=1", o_fifo_full); end
        checks++; if (o_err_cnt !== 8'd0) begin failures++; $display("FAIL full_err4 got=%0d exp=0", o_err_cnt); end
        send_wait(mk_frame(DEV, 8'd5));
        checks++; if (o_err_cnt !== 8'd1) begin failures++; $display("FAIL full_err5 got=%0d exp=1", o_err_cnt); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (o_key !== 8'(k)) begin failures++; $display("FAIL full_order got=%h exp=%h", o_key, 8'(k)); end
            i_key_rdy = 1'b1;
            tick(1);
            i_key_rdy = 1'b0;
            checks++; if (o_fifo_full !== 1'b0) begin failures++; $display("FAIL full_clear got=%0b exp=0", o_fifo_full); end
        end
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL full_drain got=%0b exp=0", o_key_vld); end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int k = 1; k <= 4; k++) send_wait(mk_frame(DEV, 8'(k)));
        pulse(mk_frame(DEV, 8'd5));
        tick(1);
        i_key_rdy = 1'b1;
        tick(1);
        i_key_rdy = 1'b0;
        tick(1);
        checks++; if (o_err_cnt !== 8'd1) begin failures++; $display("FAIL pp_err got=%0d exp=1", o_err_cnt); end
        checks++; if (o_fifo_full !== 1'b0) begin failures++; $display("FAIL pp_full got=%0b exp=0", o_fifo_full); end
        for (int k = 2; k <= 4; k++) begin
            checks++; if (o_key !== 8'(k)) begin failures++; $display("FAIL pp_order got=%h exp=%h", o_key, 8'(k)); end
            i_key_rdy = 1'b1;
            tick(1);
            i_key_rdy = 1'b0;
        end
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL pp_occ3 got=%0b exp=0", o_key_vld); end
    endtask

    task automatic test_ignored();
        do_reset();
        pulse(mk_frame(DEV, 8'h21));
        pulse(mk_frame(DEV, 8'h22));
        tick(3);
        checks++; if (o_err_cnt !== 8'd1) begin failures++; $display("FAIL ign_err got=%0d exp=1", o_err_cnt); end
        checks++; if (o_key !== 8'h21) begin failures++; $display("FAIL ign_key got=%h exp=21", o_key); end
        i_key_rdy = 1'b1;
        tick(1);
        i_key_rdy = 1'b0;
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL ign_single got=%0b exp=0", o_key_vld); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_wait(32'h00FF_4545);
        send_wait(mk_frame(DEV, 8'h01));
        send_wait(mk_frame(DEV, 8'h02));
        pulse(mk_frame(DEV, 8'h03));
        rst_n = 1'b0;
        #1;
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL rmid_vld got=%0b exp=0", o_key_vld); end
        checks++; if (o_key !== 8'h00) begin failures++; $display("FAIL rmid_key got=%h exp=00", o_key); end
        checks++; if (o_err_cnt !== 8'h00) begin failures++; $display("FAIL rmid_err got=%h exp=00", o_err_cnt); end
        tick(2);
        rst_n = 1'b1;
        tick(4);
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL rmid_nowrite got=%0b exp=0", o_key_vld); end
    endtask

`ifdef IR_KEY_REPEAT_EN
    task automatic test_repeat();
        do_reset();
        send_wait(mk_frame(DEV, 8'h18));
        checks++; if (o_key !== 8'h18) begin failures++; $display("FAIL rep_first got=%h exp=18", o_key); end
        i_key_rdy = 1'b1;
        tick(1);
        i_key_rdy = 1'b0;
        tick(495);
        i_repeat = 1'b1;
        tick(1);
        i_repeat = 1'b0;
        tick(2);
        checks++; if (o_key_vld !== 1'b1) begin failures++; $display("FAIL rep_vld got=%0b exp=1", o_key_vld); end
        checks++; if (o_key !== 8'h18) begin failures++; $display("FAIL rep_key got=%h exp=18", o_key); end
        i_key_rdy = 1'b1;
        tick(1);
        i_key_rdy = 1'b0;
        tick(1200);
        i_repeat = 1'b1;
        tick(1);
        i_repeat = 1'b0;
        tick(3);
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL rep_tmo_vld got=%0b exp=0", o_key_vld); end
        checks++; if (o_err_cnt !== 8'd1) begin failures++; $display("FAIL rep_tmo_err got=%0d exp=1", o_err_cnt); end
    endtask
`else
    task automatic test_repeat();
        do_reset();
        send_wait(mk_frame(DEV, 8'h18));
        i_key_rdy = 1'b1;
        tick(1);
        i_key_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_repeat = 1'b1;
            tick(1);
            i_repeat = 1'b0;
            tick(4);
        end
        checks++; if (o_key_vld !== 1'b0) begin failures++; $display("FAIL norep_vld got=%0b exp=0", o_key_vld); end
        checks++; if (o_err_cnt !== 8'd0) begin failures++; $display("FAIL norep_err got=%0d exp=0", o_err_cnt); end
    endtask
`endif

    task automatic test_random();
        ev_t        sched[$];
        ev_t        ev;
        logic [7:0] q[$];
        logic [7:0] a, ai, c, ci, exp_key;
        int         m_err;
        int         gap;
        bit         full_pre, pend, ok;
        do_reset();
        m_err = 0;
        gap   = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            exp_key = (q.size() != 0) ? q[0] : 8'h00;
            checks++; if (o_key_vld !== (q.size() != 0)) begin failures++; $display("FAIL rnd_vld cyc=%0d got=%0b exp=%0b", cyc, o_key_vld, q.size() != 0); end
            checks++; if (o_key !== exp_key) begin failures++; $display("FAIL rnd_key cyc=%0d got=%h exp=%h", cyc, o_key, exp_key); end
            checks++; if (o_fifo_full !== (q.size() == 4)) begin failures++; $display("FAIL rnd_full cyc=%0d got=%0b exp=%0b", cyc, o_fifo_full, q.size() == 4); end
            checks++; if (o_err_cnt !== 8'(m_err)) begin failures++; $display("FAIL rnd_err cyc=%0d got=%0d exp=%0d", cyc, o_err_cnt, m_err); end

            i_key_rdy  = ($urandom_range(0, 2) == 0);
            i_data_vld = 1'b0;
`ifndef IR_KEY_REPEAT_EN
            i_repeat   = ($urandom_range(0, 3) == 0);
`endif
            ok = 1'b0;
            c  = 8'h00;
            if (gap > 0) gap--;
            if (gap == 0 && $urandom_range(0, 2) == 0) begin
                a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : DEV;
                c  = 8'($urandom);
                ai = ~a;
                ci = ~c;
                case ($urandom_range(0, 5))
                    0:       ci = ci ^ 8'($urandom_range(1, 255));
                    1:       ai = ai ^ 8'($urandom_range(1, 255));
                    default: ;
                endcase
                ok         = (c == ~ci) && (a == ~ai) && (a == DEV);
                i_data     = {a, ai, c, ci};
                i_data_vld = 1'b1;
                gap        = 3;
            end

            full_pre = (q.size() == 4);
            pend     = 1'b0;
            if (sched.size() != 0 && sched[0].cyc == cyc) begin
                ev   = sched.pop_front();
                pend = 1'b1;
            end
            if (i_key_rdy && q.size() != 0) void'(q.pop_front());
            if (pend) begin
                if (!ev.ok || full_pre) m_err = (m_err < 255) ? m_err + 1 : 255;
                else q.push_back(ev.key);
            end
            if (i_data_vld) sched.push_back('{cyc: cyc + 2, ok: ok, key: c});
            tick(1);
        end
        i_data_vld = 1'b0;
        i_key_rdy  = 1'b0;
        i_repeat   = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_reject();
        test_full();
        test_push_pop_full();
        test_ignored();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_key_dec.md
IR_KEY_DEC -- requirements
Module: ir_key_dec

Interface
REQ-001 SHALL have parameter: DEV_ADDR, 8'h00, accepted device address.
REQ-002 SHALL have parameter: CHK_ADDR, 1, 1 = reject frames whose address differs from DEV_ADDR.
REQ-003 SHALL have parameter: FIFO_AW, 2, key FIFO address width (depth 2**FIFO_AW).
REQ-004 SHALL have parameter: REP_TMO, 6000000, repeat-hold timeout in clk cycles (120 ms at 50 MHz, < 2**24).
REQ-005 SHALL have port: clk  input  1  system clock (50 MHz).
REQ-006 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: i_data  input  32  decoded IR frame, [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
REQ-008 SHALL have port: i_data_vld  input  1  one-cycle pulse, i_data valid.
REQ-009 SHALL have port: i_repeat  input  1  one-cycle pulse, repeat code received.
REQ-010 SHALL have port: i_key_rdy  input  1  consumer accepts head key.
REQ-011 SHALL have port: o_key  output  8  FIFO head command byte, 8'h00 when empty.
REQ-012 SHALL have port: o_key_vld  output  1  FIFO non-empty.
REQ-013 SHALL have port: o_fifo_full  output  1  FIFO holds 2**FIFO_AW entries.
REQ-014 SHALL have port: o_err_cnt  output  8  saturating count of rejected frames/keys.

Function
REQ-015 SHALL implement FSM states IDLE, CHECK, PUSH, DROP; IDLE->CHECK on i_data_vld (i_data registered that cycle); CHECK->PUSH if valid else DROP; PUSH->IDLE; DROP->IDLE.
REQ-016 SHALL deem a frame valid only when cmd == ~cmd byte, addr == ~addr byte, and (CHK_ADDR==0 or addr == DEV_ADDR).
REQ-017 SHALL, with i_data_vld in cycle N and empty FIFO, write cmd in cycle N+2 and assert o_key_vld with o_key = cmd from cycle N+3.
REQ-018 SHALL ignore i_data_vld and i_repeat outside IDLE and increment o_err_cnt once per ignored i_data_vld.
REQ-019 SHALL increment o_err_cnt in DROP, and in PUSH when FIFO is full (key discarded).
REQ-020 SHALL saturate o_err_cnt at 8'hFF.
REQ-021 SHALL implement a show-ahead FIFO; pop occurs in any cycle with o_key_vld & i_key_rdy.
REQ-022 SHALL evaluate full on pre-pop occupancy: push into a full FIFO is dropped even if a pop occurs the same cycle.
REQ-023 SHALL complete a simultaneous push and pop on a non-full, non-empty FIFO with unchanged occupancy.
REQ-024 SHALL wrap read/write pointers modulo 2**FIFO_AW, using an extra pointer bit for full/empty.
REQ-025 SHALL ignore i_key_rdy while the FIFO is empty.

Reset
REQ-026 SHALL, on rst_n low, asynchronously set state IDLE, FIFO empty, o_key 8'h00, o_key_vld 0, o_fifo_full 0, o_err_cnt 0, last-key invalid, timeout counter 0.
REQ-027 SHALL discard any frame in CHECK/PUSH when reset asserts mid-operation; no partial FIFO write.

Configuration
REQ-028 SHALL support macro IR_KEY_REPEAT_EN; when defined, a valid push stores cmd as last key, sets last-key valid and clears a 24-bit timeout counter.
REQ-029 SHALL, with IR_KEY_REPEAT_EN, on i_repeat in IDLE with last key valid, enter PUSH and write last key (latency as REQ-017), restarting the timeout counter.
REQ-030 SHALL, with IR_KEY_REPEAT_EN, clear last-key valid when the timeout counter reaches REP_TMO or a frame enters DROP; i_repeat with last key invalid increments o_err_cnt.
REQ-031 SHALL, without IR_KEY_REPEAT_EN, ignore i_repeat entirely and omit last-key and timeout logic.

Verification
REQ-032 SHALL cover: i_data=32'h00FF_45BA pulse, i_key_rdy=0 -> o_key_vld=1, o_key=8'h45 three cycles later, o_err_cnt=0.
REQ-033 SHALL cover: i_data=32'h00FF_4545 -> no FIFO write, o_err_cnt=1; with CHK_ADDR=1, i_data=32'h01FE_45BA -> o_err_cnt=2.
REQ-034 SHALL cover: five valid frames (cmd 1..5), i_key_rdy=0 -> o_fifo_full=1 after fourth, o_err_cnt=1, then popping yields 1,2,3,4 in order.
REQ-035 SHALL cover: full FIFO, fifth frame PUSH in same cycle as pop -> key dropped, o_err_cnt increments, occupancy becomes 3.
REQ-036 SHALL cover (IR_KEY_REPEAT_EN, REP_TMO=1000): frame cmd 8'h18 then i_repeat after 500 cycles -> second 8'h18 queued; i_repeat 1200 cycles later -> no push, o_err_cnt=1.
REQ-037 SHALL cover: rst_n low during CHECK with FIFO holding two keys -> o_key_vld=0, o_key=8'h00, o_err_cnt=0 immediately.
